// File: rtl/ps2_keypad_pkg.sv
// Scan-code set 2 constants, receive FSM encoding and the 4x4 block to CHIP-8 hex keymap.
package ps2_keypad_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_KEY_0 = 8'h22;
  localparam logic [7:0] SC_KEY_1 = 8'h16;
  localparam logic [7:0] SC_KEY_2 = 8'h1E;
  localparam logic [7:0] SC_KEY_3 = 8'h26;
  localparam logic [7:0] SC_KEY_4 = 8'h15;
  localparam logic [7:0] SC_KEY_5 = 8'h1D;
  localparam logic [7:0] SC_KEY_6 = 8'h24;
  localparam logic [7:0] SC_KEY_7 = 8'h1C;
  localparam logic [7:0] SC_KEY_8 = 8'h1B;
  localparam logic [7:0] SC_KEY_9 = 8'h23;
  localparam logic [7:0] SC_KEY_A = 8'h1A;
  localparam logic [7:0] SC_KEY_B = 8'h21;
  localparam logic [7:0] SC_KEY_C = 8'h25;
  localparam logic [7:0] SC_KEY_D = 8'h2D;
  localparam logic [7:0] SC_KEY_E = 8'h2B;
  localparam logic [7:0] SC_KEY_F = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] k;
  } key_map_t;

  function automatic key_map_t sc_to_key(input logic [7:0] sc);
    key_map_t m;
    m.valid = 1'b1;
    m.k     = 4'h0;
    case (sc)
      SC_KEY_0: m.k = 4'h0;
      SC_KEY_1: m.k = 4'h1;
      SC_KEY_2: m.k = 4'h2;
      SC_KEY_3: m.k = 4'h3;
      SC_KEY_4: m.k = 4'h4;
      SC_KEY_5: m.k = 4'h5;
      SC_KEY_6: m.k = 4'h6;
      SC_KEY_7: m.k = 4'h7;
      SC_KEY_8: m.k = 4'h8;
      SC_KEY_9: m.k = 4'h9;
      SC_KEY_A: m.k = 4'hA;
      SC_KEY_B: m.k = 4'hB;
      SC_KEY_C: m.k = 4'hC;
      SC_KEY_D: m.k = 4'hD;
      SC_KEY_E: m.k = 4'hE;
      SC_KEY_F: m.k = 4'hF;
      default:  m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_keypad_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame FSM and idle timeout.
// rx_valid/rx_err are 1-cycle registered strobes; the keyboard cannot be back-pressured.
module ps2_keypad_rx
  import ps2_keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // filt follows clk_s only after FILTER_LEN consecutive differing samples
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          flip;
  logic          fe;

  assign flip = (clk_s != filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fe   = flip && filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt) begin
      filt_cnt <= '0;
    end else if (flip) begin
      filt     <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          valid_nxt;
  logic          err_nxt;

  assign timeout = (state != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fe) begin
      case (state)
        ST_IDLE:   if (!data_s) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (fe) begin
      case (state)
        ST_IDLE: err_nxt = data_s;
        ST_STOP: begin
          // odd parity over data + parity bit, and a high stop bit
          if (data_s && (^{shift, par})) valid_nxt = 1'b1;
          else                           err_nxt   = 1'b1;
        end
        default: ;
      endcase
    end else if (timeout) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= valid_nxt;
      rx_err   <= err_nxt;
      if (fe || state == ST_IDLE) tcnt <= '0;
      else if (!timeout)          tcnt <= tcnt + TW'(1);
      if (fe) begin
        case (state)
          ST_IDLE: bit_cnt <= '0;
          ST_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par <= data_s;
          default: ;
        endcase
      end
    end
  end

  assign rx_byte = shift;
  assign busy    = (state != ST_IDLE);

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to CHIP-8 hex keypad: tracks make/break/extended prefixes and keeps a held-key bitmap.
// Key outputs register one cycle after a received byte; no backpressure (events are strobes).
module ps2_keypad
  import ps2_keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_state,
  output logic        key_down,
  output logic [3:0]  key_code,
  output logic        frame_err,
  output logic        busy
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       brk;
  logic       ext;
  key_map_t   km;

  ps2_keypad_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  assign frame_err = rx_err;
  assign km        = sc_to_key(rx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      key_down  <= 1'b0;
      key_code  <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
    end else begin
      key_down <= 1'b0;
      if (rx_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // extended codes never alias onto keypad keys
          if (!ext && km.valid) begin
            if (brk) begin
              key_state[km.k] <= 1'b0;
            end else begin
              key_state[km.k] <= 1'b1;
              if (!key_state[km.k]) begin
                key_down <= 1'b1;
                key_code <= km.k;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Scoreboard bench for ps2_keypad: open-drain PS/2 pin driver, keypad reference model, decoupled monitor.
module tb_ps2_keypad;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TMO  = 500;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kclk_low = 1'b0;
  logic        kdat_low = 1'b0;
  logic        ps2_clk, ps2_data;
  logic [15:0] key_state;
  logic        key_down;
  logic [3:0]  key_code;
  logic        frame_err;
  logic        busy;

  assign ps2_clk  = kclk_low ? 1'b0 : 1'b1;
  assign ps2_data = kdat_low ? 1'b0 : 1'b1;

  ps2_keypad #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_state(key_state),
    .key_down (key_down),
    .key_code (key_code),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_code_q[$];
  int exp_err_q[$];
  int mon_e;

  logic [15:0] m_keys = '0;
  bit          m_brk = 1'b0;
  bit          m_ext = 1'b0;
  logic [7:0]  sc_tab [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                               8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};

  function automatic int key_of(input logic [7:0] b);
    for (int k = 0; k < 16; k++) if (sc_tab[k] == b) return k;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      k = key_of(b);
      if (!m_ext && k >= 0) begin
        if (m_brk) m_keys[k] = 1'b0;
        else begin
          if (!m_keys[k]) exp_code_q.push_back(k);
          m_keys[k] = 1'b1;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_err();
    exp_err_q.push_back(1);
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_keys(input string name);
    check(name, int'(key_state), int'(m_keys));
  endtask

  task automatic drive_bit(input bit v);
    @(negedge clk);
    kdat_low = ~v;
    repeat (HALF / 2) @(negedge clk);
    kclk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    kclk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input bit bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ bad_par);
    drive_bit(1'b1);
    kdat_low = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    send_raw(b, 1'b0);
  endtask

  task automatic send_bad(input logic [7:0] b);
    model_err();
    send_raw(b, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_down === 1'b1) begin
        checks++;
        if (exp_code_q.size() == 0) begin
          errors++;
          $display("FAIL key_down: unexpected strobe code=%0h", key_code);
        end else begin
          mon_e = exp_code_q.pop_front();
          if (key_code !== 4'(mon_e)) begin
            errors++;
            $display("FAIL key_code: got %0h expected %0h", key_code, mon_e);
          end
        end
      end
      if (frame_err === 1'b1) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          errors++;
          $display("FAIL frame_err: unexpected pulse, expected none");
        end else begin
          mon_e = exp_err_q.pop_front();
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int maxbusy;
    int r, k;
    logic [7:0] b;

    repeat (4) @(negedge clk);
    check("reset key_state", int'(key_state), 0);
    check("reset key_down", int'(key_down), 0);
    check("reset key_code", int'(key_code), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: make/break of key 1
    send(8'h16);
    check("t1 make", int'(key_state), 16'h0002);
    send(8'hF0); send(8'h16);
    check("t1 break", int'(key_state), 16'h0000);

    // 2: typematic
    repeat (3) send(8'h2A);
    check("t2 typematic", int'(key_state), 16'h8000);
    send(8'hF0); send(8'h2A);

    // 3: two keys held
    send(8'h1C); check("t3 a", int'(key_state), 16'h0080);
    send(8'h22); check("t3 b", int'(key_state), 16'h0081);
    send(8'hF0); send(8'h1C); check("t3 c", int'(key_state), 16'h0001);

    // 4: parity error then good frame
    send_bad(8'h16); check_keys("t4 bad parity");
    send(8'h16); check("t4 good", int'(key_state), 16'h0003);

    // 5: extended codes ignored
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_keys("t5 ext");
    send(8'h1A); check("t5 key A", int'(key_state), 16'h0403);

    // 6a: timeout after start + 4 data bits
    model_err();
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge clk);
    kdat_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    kclk_low = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * TMO; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == HALF) begin kclk_low = 1'b0; kdat_low = 1'b0; end
      if (n == 100) check("t6 busy mid-frame", int'(busy), 1);
      if (frame_err) break;
    end
    check("t6 timeout cycles", n, SYNC + FILT + TMO);
    repeat (5) @(negedge clk);
    check("t6 busy after timeout", int'(busy), 0);
    check_keys("t6 keys after timeout");

    // 6b: short glitches on the clock, data high then low
    maxbusy = 0;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      kdat_low = (g == 1);
      kclk_low = 1'b1;
      repeat (3) @(negedge clk);
      kclk_low = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (busy) maxbusy = 1;
      end
      kdat_low = 1'b0;
    end
    check("t6 glitch busy", maxbusy, 0);

    // 6c: reset mid-frame
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    kclk_low = 1'b0;
    kdat_low = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 rst key_state", int'(key_state), 0);
    check("t6 rst key_code", int'(key_code), 0);
    check("t6 rst busy", int'(busy), 0);
    check("t6 rst key_down", int'(key_down), 0);
    check("t6 rst frame_err", int'(frame_err), 0);
    m_keys = '0; m_brk = 1'b0; m_ext = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(8'h16);
    check("t6 after reset", int'(key_state), 16'h0002);

    // randomized traffic against the model
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 10);
      k = $urandom_range(0, 15);
      if (r <= 4) send(sc_tab[k]);
      else if (r <= 7) begin send(8'hF0); send(sc_tab[k]); end
      else if (r == 8) begin
        do b = 8'($urandom_range(0, 255));
        while (key_of(b) >= 0 || b == 8'hF0 || b == 8'hE0);
        send(b);
      end
      else if (r == 9) send_bad(8'($urandom_range(0, 255)));
      else begin send(8'hE0); send(sc_tab[k]); end
      check_keys("random keys");
    end

    repeat (50) @(negedge clk);
    check("pending key_down", exp_code_q.size(), 0);
    check("pending frame_err", exp_err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
